gf_mult_serial: RTL and testbench

Parametrised bit-serial multiplier over GF(2^M) with a programmable reduction polynomial and valid/ready handshakes on both sides. It generalises the fixed multiply-by-constant nibble tables used in the S-AES MixColumns path: both operands are arbitrary, and the field width and polynomial are parameters. The intended uses are the S-AES MixColumns/InvMixColumns datapath (M=4, x^4+x+1) and the wider-field experiments (M=8, AES polynomial). Each product takes one iteration per operand bit.

---
 rtl/gf_mult_serial.sv | 122 ++++++++++++
 tb/tb_gf_mult_serial.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_mult_serial.sv
// gf_mult_serial
//   Bit-serial multiplier over GF(2^M). One operand pair is accepted, then
//   the product a*b mod P(x) is built MSB-first, one multiplier bit per
//   cycle, and presented until the consumer takes it.
//
// Parameters
//   M     field width in bits (2..16)
//   POLY  low M bits of the reduction polynomial; the x^M term is implicit
//         (4'h3 = x^4+x+1, 8'h1B = AES field at M=8)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand pair presented
//   in_ready   block can accept an operand pair (IDLE only)
//   in_a       multiplicand
//   in_b       multiplier
//   out_valid  product available (DONE only)
//   out_ready  downstream accepts the product
//   out_data   product, registered; meaningful only while out_valid=1
//   busy       high in RUN or DONE
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its data stable until that
// edge. ready never depends combinationally on valid; in_ready is a
// function of state only, so there is no path from out_ready to in_ready.
module gf_mult_serial #(
  parameter int           M    = 4,
  parameter logic [M-1:0] POLY = M'(4'h3)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_a,
  input  logic [M-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data,
  output logic         busy
);

  localparam int CW = $clog2(M);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [M-1:0]  a_r;
  logic [M-1:0]  b_r;
  logic [M-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [M-1:0]  step_val;

  // Multiply by x, reducing the bit shifted out of position M-1.
  function automatic logic [M-1:0] xt(input logic [M-1:0] x);
    return {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY : '0);
  endfunction

  // Horner step: acc*x plus the current multiplier bit times a.
  assign step_val = xt(acc) ^ (b_r[cnt] ? a_r : '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)    state_next = RUN;
      RUN:     if (cnt == '0)   state_next = DONE;
      DONE:    if (out_ready)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Datapath. acc is held through DONE so out_data stays stable while the
  // consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= in_a;
            b_r <= in_b;
            acc <= '0;
            cnt <= CW'(M - 1);
          end
        end
        RUN: begin
          acc <= step_val;
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = acc;

endmodule

// File: tb/tb_gf_mult_serial.sv
// Bench for gf_mult_serial: one M=4 (x^4+x+1) and one M=8 (AES polynomial)
// instance sharing clock and reset. Directed vectors with hand-computed
// products, a backpressure and a mid-run reset scenario, then a short
// streaming run with random out_ready scored against a reference multiply.
module tb_gf_mult_serial;

  logic       clk;
  logic       rst;

  logic       in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0] in_a4, in_b4, out_data4;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0] in_a8, in_b8, out_data8;

  int n_checks = 0;
  int n_errors = 0;

  gf_mult_serial #(.M(4), .POLY(4'h3)) u_gf4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .busy(busy4)
  );

  gf_mult_serial #(.M(8), .POLY(8'h1B)) u_gf8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8), .in_b(in_b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .busy(busy8)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison helper
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference multiply, LSB-first shift-and-add.
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b,
                                        input bit wide);
    logic [7:0] p;
    logic [7:0] x;
    logic       hi;
    int         m;
    m = wide ? 8 : 4;
    p = '0;
    x = a;
    for (int i = 0; i < m; i++) begin
      if (b[i]) p = p ^ x;
      hi = x[m-1];
      x  = (x << 1) & (wide ? 8'hFF : 8'h0F);
      if (hi) x = x ^ (wide ? 8'h1B : 8'h03);
    end
    return p;
  endfunction

  // Driver tasks
  function automatic logic sel_ready(input bit wide);
    return wide ? in_ready8 : in_ready4;
  endfunction

  function automatic logic sel_ovalid(input bit wide);
    return wide ? out_valid8 : out_valid4;
  endfunction

  function automatic logic [7:0] sel_data(input bit wide);
    return wide ? out_data8 : {4'h0, out_data4};
  endfunction

  function automatic logic sel_busy(input bit wide);
    return wide ? busy8 : busy4;
  endfunction

  task automatic drive_in(input bit wide, input logic v, input logic [7:0] a,
                          input logic [7:0] b);
    if (wide) begin
      in_valid8 = v; in_a8 = a; in_b8 = b;
    end else begin
      in_valid4 = v; in_a4 = a[3:0]; in_b4 = b[3:0];
    end
  endtask

  // Accept one pair; returns once the accept edge has passed (#1 after it).
  task automatic offer(input bit wide, input logic [7:0] a, input logic [7:0] b,
                       input string tag);
    int waited;
    waited = 0;
    while (!sel_ready(wide) && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, "_ready"}, sel_ready(wide), 1'b1);
    drive_in(wide, 1'b1, a, b);
    @(posedge clk); #1;
    // Scramble the operand lines: the product must use the sampled values.
    drive_in(wide, 1'b0, ~a, ~b);
    check({tag, "_busy"}, sel_busy(wide), 1'b1);
    check({tag, "_inrdy_low"}, sel_ready(wide), 1'b0);
  endtask

  // Wait for out_valid; returns the number of edges since the accept edge.
  task automatic wait_valid(input bit wide, output int lat);
    lat = 0;
    while (!sel_ovalid(wide) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Full transaction with out_ready held high.
  task automatic do_mul(input bit wide, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input string tag);
    int lat;
    offer(wide, a, b, tag);
    wait_valid(wide, lat);
    check({tag, "_lat"}, lat, wide ? 8 : 4);
    check({tag, "_data"}, sel_data(wide), exp);
    @(posedge clk); #1;
    check({tag, "_drop"}, sel_ovalid(wide), 1'b0);
  endtask

  // Continuous offers with random out_ready; every product must appear
  // exactly once, in order.
  task automatic stream(input bit wide, input int n, input string tag);
    logic [7:0] exp_q[$];
    logic [7:0] ca, cb, mask;
    logic       cv, ordy, acc_now, out_hs;
    int         sent, got, guard;
    mask = wide ? 8'hFF : 8'h0F;
    sent = 0; got = 0; guard = 0; cv = 1'b0; ca = '0; cb = '0;
    while (got < n && guard < 20000) begin
      if (!cv && sent < n) begin
        ca = 8'($urandom_range(0, 255)) & mask;
        cb = 8'($urandom_range(0, 255)) & mask;
        cv = 1'b1;
      end
      drive_in(wide, cv, ca, cb);
      ordy = 1'($urandom_range(0, 1));
      if (wide) out_ready8 = ordy; else out_ready4 = ordy;
      acc_now = cv && sel_ready(wide);
      out_hs  = sel_ovalid(wide) && ordy;
      if (out_hs) begin
        if (exp_q.size() == 0) begin
          check({tag, "_dup"}, 1, 0);
        end else begin
          check({tag, "_data"}, sel_data(wide), exp_q.pop_front());
        end
        got++;
      end
      if (acc_now) begin
        exp_q.push_back(gf_ref(ca, cb, wide));
        sent++;
        cv = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end
    drive_in(wide, 1'b0, '0, '0);
    if (wide) out_ready8 = 1'b1; else out_ready4 = 1'b1;
    check({tag, "_count"}, got, n);
    check({tag, "_left"}, exp_q.size(), 0);
  endtask

  logic [3:0] table_a4 [16];
  int         lat;

  initial begin
    table_a4 = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h3, 4'h7, 4'hB, 4'hF,
                 4'h6, 4'h2, 4'hE, 4'hA, 4'h5, 4'h1, 4'hD, 4'h9};
    rst = 1'b1;
    in_valid4 = 0; in_a4 = '0; in_b4 = '0; out_ready4 = 1'b1;
    in_valid8 = 0; in_a8 = '0; in_b8 = '0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ovalid4", out_valid4, 1'b0);
    check("rst_busy4", busy4, 1'b0);
    check("rst_data4", out_data4, 4'h0);
    check("rst_ovalid8", out_valid8, 1'b0);
    check("rst_busy8", busy8, 1'b0);
    check("rst_data8", out_data8, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    check("rst_inrdy4", in_ready4, 1'b1);
    check("rst_inrdy8", in_ready8, 1'b1);

    // Directed M=4 vectors
    do_mul(1'b0, 8'h4, 8'h8, 8'h6, "m4_4x8");
    for (int b = 0; b < 16; b++) begin
      do_mul(1'b0, 8'h4, 8'(b), {4'h0, table_a4[b]}, $sformatf("m4_4x%0h", b));
    end
    do_mul(1'b0, 8'h9, 8'hE, 8'h7, "m4_9xE");
    do_mul(1'b0, 8'hF, 8'h0, 8'h0, "m4_Fx0");

    // Directed M=8 vectors
    do_mul(1'b1, 8'h57, 8'h83, 8'hC1, "m8_57x83");
    do_mul(1'b1, 8'h57, 8'h02, 8'hAE, "m8_57x02");

    // Backpressure: 10 stalled cycles in DONE with new offers ignored
    out_ready4 = 1'b0;
    offer(1'b0, 8'h9, 8'hE, "bp");
    wait_valid(1'b0, lat);
    check("bp_lat", lat, 4);
    for (int i = 0; i < 10; i++) begin
      drive_in(1'b0, 1'b1, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
      check("bp_inrdy", in_ready4, 1'b0);
      @(posedge clk); #1;
      check("bp_ovalid", out_valid4, 1'b1);
      check("bp_data", out_data4, 4'h7);
    end
    drive_in(1'b0, 1'b0, '0, '0);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_ovalid", out_valid4, 1'b0);
    check("bp_rel_inrdy", in_ready4, 1'b1);
    check("bp_rel_busy", busy4, 1'b0);

    // Reset at RUN step 2
    offer(1'b0, 8'hF, 8'hF, "rr");
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("rr_ovalid", out_valid4, 1'b0);
    check("rr_busy", busy4, 1'b0);
    check("rr_inrdy", in_ready4, 1'b1);
    check("rr_data", out_data4, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    do_mul(1'b0, 8'h3, 8'h3, 8'h5, "rr_3x3");

    // Streaming with random backpressure
    stream(1'b0, 60, "st4");
    stream(1'b1, 30, "st8");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
